// File: rtl/l2_pkg.sv
// Shared types and constants for the L2 cache controller: FSM state codes,
// default widths and the saturating counter helper used by the optional stats.
package l2_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int IDX_W_DEF  = 4;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t LOOKUP = 3'd1;
    localparam state_t MEM_RD = 3'd2;
    localparam state_t MEM_WR = 3'd3;
    localparam state_t DONE   = 3'd4;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/l2_cache_ctrl_if.sv
// Bus-side (arbiter/L1 -> L2) and memory-side (L2 -> main memory) handshake
// bundles. The controller is the slave of the bus and the master of memory.
interface l2_bus_if import l2_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              l2_start;
    logic              l2_done;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_we;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;

    modport master (output l2_start, bus_addr, bus_we, bus_wdata,
                    input  l2_done, bus_rdata);
    modport slave  (input  l2_start, bus_addr, bus_we, bus_wdata,
                    output l2_done, bus_rdata);
endinterface

interface l2_mem_if import l2_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_rdata, mem_ack);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_rdata, mem_ack);
endinterface

// File: rtl/l2_line_array.sv
// Direct-mapped line storage: combinational read, one synchronous write port.
// A write always marks the line valid; only valid bits are cleared by reset.
module l2_line_array import l2_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic                     rd_valid,
    output logic [ADDR_W-IDX_W-1:0]  rd_tag,
    output logic [DATA_W-1:0]        rd_data,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [ADDR_W-IDX_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0]        wr_data
);
    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W;

    logic [LINES-1:0]             valid_q;
    logic [LINES-1:0][TAG_W-1:0]  tag_q;
    logic [LINES-1:0][DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst)
            valid_q <= '0;
        else if (wr_en)
            valid_q[wr_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];
endmodule

// File: rtl/l2_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L2 controller behind the bus
// arbiter. Optional hit/miss counters are built when L2_STATS_EN is defined.
module l2_cache_ctrl import l2_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic      clk,
    input  logic      rst,
    l2_bus_if.slave   bus,
    l2_mem_if.master  mem
`ifdef L2_STATS_EN
    ,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
`endif
);
    localparam int TAG_W = ADDR_W - IDX_W;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] req_addr, req_addr_nxt;
    logic              req_we, req_we_nxt;
    logic [DATA_W-1:0] req_wdata, req_wdata_nxt;
    logic [DATA_W-1:0] rdata_q, rdata_nxt;
    logic              done_q, done_nxt;
    logic              mem_req_q, mem_req_nxt;
    logic              mem_we_q, mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_nxt;

    logic              arr_wr_en;
    logic [DATA_W-1:0] arr_wr_data;
    logic              line_valid;
    logic [TAG_W-1:0]  line_tag;
    logic [DATA_W-1:0] line_data;
    logic              hit;

    l2_line_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W)) u_lines (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (req_addr[IDX_W-1:0]),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (arr_wr_en),
        .wr_idx   (req_addr[IDX_W-1:0]),
        .wr_tag   (req_addr[ADDR_W-1:IDX_W]),
        .wr_data  (arr_wr_data)
    );

    assign hit = line_valid && (line_tag == req_addr[ADDR_W-1:IDX_W]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_addr    <= '0;
            req_we      <= 1'b0;
            req_wdata   <= '0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state       <= state_nxt;
            req_addr    <= req_addr_nxt;
            req_we      <= req_we_nxt;
            req_wdata   <= req_wdata_nxt;
            rdata_q     <= rdata_nxt;
            done_q      <= done_nxt;
            mem_req_q   <= mem_req_nxt;
            mem_we_q    <= mem_we_nxt;
            mem_addr_q  <= mem_addr_nxt;
            mem_wdata_q <= mem_wdata_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.l2_start) state_nxt = LOOKUP;
            LOOKUP:  state_nxt = req_we ? MEM_WR : (hit ? DONE : MEM_RD);
            MEM_RD:  if (mem.mem_ack) state_nxt = DONE;
            MEM_WR:  if (mem.mem_ack) state_nxt = DONE;
            DONE:    if (!bus.l2_start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // l2_done follows l2_start while in DONE, so it rises one edge after entry
    // and falls on the same edge that returns the FSM to IDLE.
    always_comb begin
        req_addr_nxt  = req_addr;
        req_we_nxt    = req_we;
        req_wdata_nxt = req_wdata;
        rdata_nxt     = rdata_q;
        done_nxt      = done_q;
        mem_req_nxt   = mem_req_q;
        mem_we_nxt    = mem_we_q;
        mem_addr_nxt  = mem_addr_q;
        mem_wdata_nxt = mem_wdata_q;
        arr_wr_en     = 1'b0;
        arr_wr_data   = req_wdata;
        case (state)
            IDLE: begin
                if (bus.l2_start) begin
                    req_addr_nxt  = bus.bus_addr;
                    req_we_nxt    = bus.bus_we;
                    req_wdata_nxt = bus.bus_wdata;
                end
            end
            LOOKUP: begin
                if (req_we) begin
                    arr_wr_en     = hit;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = 1'b1;
                    mem_addr_nxt  = req_addr;
                    mem_wdata_nxt = req_wdata;
                end else if (hit) begin
                    rdata_nxt = line_data;
                end else begin
                    mem_req_nxt  = 1'b1;
                    mem_we_nxt   = 1'b0;
                    mem_addr_nxt = req_addr;
                end
            end
            MEM_RD: begin
                if (mem.mem_ack) begin
                    arr_wr_en   = 1'b1;
                    arr_wr_data = mem.mem_rdata;
                    rdata_nxt   = mem.mem_rdata;
                    mem_req_nxt = 1'b0;
                end
            end
            MEM_WR: begin
                if (mem.mem_ack) mem_req_nxt = 1'b0;
            end
            DONE:    done_nxt = bus.l2_start;
            default: ;
        endcase
    end

    assign bus.l2_done   = done_q;
    assign bus.bus_rdata = rdata_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

`ifdef L2_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == LOOKUP) begin
            if (hit) hit_cnt  <= sat_inc16(hit_cnt);
            else     miss_cnt <= sat_inc16(miss_cnt);
        end
    end
`endif
endmodule

// File: tb/tb_l2_cache_ctrl.sv
// Self-checking bench for l2_cache_ctrl: directed scenarios plus randomized
// traffic against a line-level cache model and a flat memory array.
module tb_l2_cache_ctrl;
    logic clk = 1'b0;
    logic rst;

    l2_bus_if #(.ADDR_W(8), .DATA_W(8)) bus ();
    l2_mem_if #(.ADDR_W(8), .DATA_W(8)) mem ();

`ifdef L2_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    l2_cache_ctrl #(.ADDR_W(8), .DATA_W(8), .IDX_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .mem (mem)
`ifdef L2_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model: main memory plus which full address each line holds
    logic [7:0] mem_arr [256];
    bit         m_valid [16];
    logic [7:0] m_addr  [16];
    logic [7:0] m_data  [16];
    int         m_hits, m_misses;

    // observations from the last transaction
    bit         o_req, o_req_we, o_timeout, o_unstable, o_done_after;
    logic [7:0] o_req_addr, o_req_wdata, o_rdata;
    int         o_lat;

    function automatic bit model_hit(input logic [7:0] a);
        return m_valid[a[3:0]] && (m_addr[a[3:0]] == a);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 0;
        m_hits = 0;
        m_misses = 0;
    endtask

    task automatic model_apply(input logic [7:0] a, input bit we, input logic [7:0] wd);
        bit h;
        h = model_hit(a);
        if (h) m_hits++; else m_misses++;
        if (we) begin
            if (h) m_data[a[3:0]] = wd;
            mem_arr[a] = wd;
        end else if (!h) begin
            m_valid[a[3:0]] = 1;
            m_addr[a[3:0]]  = a;
            m_data[a[3:0]]  = mem_arr[a];
        end
    endtask

    // Drives one request, plays the memory, returns once l2_done is seen high.
    // Bus fields are scrambled after the sampling edge; l2_start stays high.
    task automatic xact(input logic [7:0] a, input bit we, input logic [7:0] wd, input int dly);
        int  cnt;
        bit  acked;
        cnt = 0; acked = 0;
        o_req = 0; o_req_we = 0; o_req_addr = 0; o_req_wdata = 0;
        o_rdata = 0; o_lat = 0; o_timeout = 1; o_unstable = 0;
        bus.l2_start = 1'b1; bus.bus_addr = a; bus.bus_we = we; bus.bus_wdata = wd;
        @(posedge clk); #1;
        bus.bus_addr = 8'($urandom); bus.bus_we = 1'($urandom); bus.bus_wdata = 8'($urandom);
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            mem.mem_ack = 1'b0;
            if (mem.mem_req === 1'b1) begin
                if (!o_req) begin
                    o_req = 1; o_req_we = mem.mem_we;
                    o_req_addr = mem.mem_addr; o_req_wdata = mem.mem_wdata;
                    cnt = dly;
                end else if (mem.mem_we !== o_req_we || mem.mem_addr !== o_req_addr ||
                             mem.mem_wdata !== o_req_wdata) begin
                    o_unstable = 1;
                end
                if (!acked) begin
                    if (cnt == 0) begin
                        mem.mem_ack   = 1'b1;
                        mem.mem_rdata = o_req_we ? 8'($urandom) : mem_arr[o_req_addr];
                        acked = 1;
                    end else begin
                        cnt--;
                    end
                end
            end
            if (bus.l2_done === 1'b1) begin
                o_lat = c; o_rdata = bus.bus_rdata; o_timeout = 0;
                break;
            end
        end
        mem.mem_ack = 1'b0;
    endtask

    task automatic finish_xact();
        bus.l2_start = 1'b0;
        @(posedge clk); #1;
        o_done_after = bus.l2_done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        vectors++; if (bus.l2_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", bus.l2_done); end
        vectors++; if (bus.bus_rdata !== 8'h00) begin miscompares++; $display("FAIL reset_rdata: got %h want 00", bus.bus_rdata); end
        vectors++; if (mem.mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req: got %b want 0", mem.mem_req); end
        vectors++; if ({mem.mem_we, mem.mem_addr, mem.mem_wdata} !== 17'h0) begin miscompares++;
            $display("FAIL reset_mem_bus: got we=%b addr=%h wdata=%h want all 0", mem.mem_we, mem.mem_addr, mem.mem_wdata); end
`ifdef L2_STATS_EN
        vectors++; if ({hit_cnt, miss_cnt} !== 32'h0) begin miscompares++; $display("FAIL reset_stats: got %h/%h want 0/0", hit_cnt, miss_cnt); end
`endif
    endtask

    task automatic test_read_miss_hit();
        mem_arr[8'h35] = 8'hA5;
        xact(8'h35, 0, 8'h00, 2);
        vectors++; if (o_timeout) begin miscompares++; $display("FAIL miss_timeout: got no l2_done want l2_done"); end
        vectors++; if ({o_req, o_req_we, o_req_addr} !== {1'b1, 1'b0, 8'h35}) begin miscompares++;
            $display("FAIL miss_req: got req=%b we=%b addr=%h want 1 0 35", o_req, o_req_we, o_req_addr); end
        vectors++; if (o_rdata !== 8'hA5) begin miscompares++; $display("FAIL miss_rdata: got %h want a5", o_rdata); end
        vectors++; if (o_lat !== 5) begin miscompares++; $display("FAIL miss_latency: got %0d want 5", o_lat); end
        model_apply(8'h35, 0, 8'h00);
        finish_xact();
        xact(8'h35, 0, 8'h00, 0);
        vectors++; if (o_req !== 1'b0) begin miscompares++; $display("FAIL hit_no_req: got %b want 0", o_req); end
        vectors++; if (o_lat !== 2) begin miscompares++; $display("FAIL hit_latency: got %0d want 2", o_lat); end
        vectors++; if (o_rdata !== 8'hA5) begin miscompares++; $display("FAIL hit_rdata: got %h want a5", o_rdata); end
        model_apply(8'h35, 0, 8'h00);
        finish_xact();
        vectors++; if (o_done_after !== 1'b0) begin miscompares++; $display("FAIL hit_done_drop: got %b want 0", o_done_after); end
    endtask

    task automatic test_write();
        xact(8'h35, 1, 8'h5C, 1);
        vectors++; if ({o_req, o_req_we, o_req_addr, o_req_wdata} !== {1'b1, 1'b1, 8'h35, 8'h5C}) begin miscompares++;
            $display("FAIL write_req: got req=%b we=%b addr=%h wdata=%h want 1 1 35 5c", o_req, o_req_we, o_req_addr, o_req_wdata); end
        vectors++; if (o_lat !== 4) begin miscompares++; $display("FAIL write_latency: got %0d want 4", o_lat); end
        model_apply(8'h35, 1, 8'h5C);
        finish_xact();
        xact(8'h35, 0, 8'h00, 0);
        vectors++; if ({o_req, o_rdata} !== {1'b0, 8'h5C}) begin miscompares++;
            $display("FAIL write_then_hit: got req=%b rdata=%h want 0 5c", o_req, o_rdata); end
        model_apply(8'h35, 0, 8'h00);
        finish_xact();
        xact(8'h77, 1, 8'h3E, 0);
        model_apply(8'h77, 1, 8'h3E);
        finish_xact();
        xact(8'h77, 0, 8'h00, 0);
        vectors++; if ({o_req, o_req_we, o_rdata} !== {1'b1, 1'b0, 8'h3E}) begin miscompares++;
            $display("FAIL write_no_alloc: got req=%b we=%b rdata=%h want 1 0 3e", o_req, o_req_we, o_rdata); end
        model_apply(8'h77, 0, 8'h00);
        finish_xact();
    endtask

    task automatic test_evict();
        mem_arr[8'h45] = 8'h9D;
        xact(8'h45, 0, 8'h00, 0);
        vectors++; if ({o_req, o_req_addr, o_rdata} !== {1'b1, 8'h45, 8'h9D}) begin miscompares++;
            $display("FAIL evict_fill: got req=%b addr=%h rdata=%h want 1 45 9d", o_req, o_req_addr, o_rdata); end
        model_apply(8'h45, 0, 8'h00);
        finish_xact();
        xact(8'h35, 0, 8'h00, 0);
        vectors++; if ({o_req, o_req_addr, o_rdata} !== {1'b1, 8'h35, 8'h5C}) begin miscompares++;
            $display("FAIL evict_remiss: got req=%b addr=%h rdata=%h want 1 35 5c", o_req, o_req_addr, o_rdata); end
        model_apply(8'h35, 0, 8'h00);
        finish_xact();
    endtask

    task automatic test_hold_and_stray_ack();
        int bad;
        bad = 0;
        xact(8'h35, 0, 8'h00, 0);
        model_apply(8'h35, 0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.l2_done !== 1'b1 || mem.mem_req !== 1'b0) bad++;
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL hold_done: got %0d bad cycles want 0", bad); end
        finish_xact();
        vectors++; if (o_done_after !== 1'b0) begin miscompares++; $display("FAIL hold_drop: got %b want 0", o_done_after); end
        mem.mem_ack = 1'b1; mem.mem_rdata = 8'hFF;
        @(posedge clk); #1;
        mem.mem_ack = 1'b0;
        @(posedge clk); #1;
        xact(8'h35, 0, 8'h00, 0);
        vectors++; if ({o_req, o_lat[3:0], o_rdata} !== {1'b0, 4'd2, 8'h5C}) begin miscompares++;
            $display("FAIL stray_ack: got req=%b lat=%0d rdata=%h want 0 2 5c", o_req, o_lat, o_rdata); end
        model_apply(8'h35, 0, 8'h00);
        finish_xact();
    endtask

    task automatic test_random();
        logic [7:0] a, wd, exp_rdata;
        bit         we, exp_hit, exp_req;
        int         dly, exp_lat, errs;
        for (int n = 0; n < 60; n++) begin
            a   = 8'($urandom_range(0, 5) * 16 + $urandom_range(0, 2));
            we  = ($urandom_range(0, 2) == 0);
            wd  = 8'($urandom);
            dly = $urandom_range(0, 3);
            exp_hit   = model_hit(a);
            exp_req   = we || !exp_hit;
            exp_lat   = exp_req ? 3 + dly : 2;
            exp_rdata = exp_hit ? m_data[a[3:0]] : mem_arr[a];
            xact(a, we, wd, dly);
            errs = 0;
            if (o_timeout || o_unstable || o_req != exp_req || o_lat != exp_lat) errs++;
            if (exp_req && (o_req_addr !== a || o_req_we !== we)) errs++;
            if (we && o_req_wdata !== wd) errs++;
            if (!we && o_rdata !== exp_rdata) errs++;
            vectors++;
            if (errs != 0) begin
                miscompares++;
                $display("FAIL rand_%0d: got req=%b we=%b addr=%h wd=%h rd=%h lat=%0d unst=%b to=%b want req=%b we=%b addr=%h wd=%h rd=%h lat=%0d",
                         n, o_req, o_req_we, o_req_addr, o_req_wdata, o_rdata, o_lat, o_unstable, o_timeout,
                         exp_req, we, a, wd, exp_rdata, exp_lat);
            end
            model_apply(a, we, wd);
            finish_xact();
        end
`ifdef L2_STATS_EN
        vectors++; if (hit_cnt !== 16'(m_hits) || miss_cnt !== 16'(m_misses)) begin miscompares++;
            $display("FAIL stats_counts: got %0d/%0d want %0d/%0d", hit_cnt, miss_cnt, m_hits, m_misses); end
`endif
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 0;
        bus.l2_start = 1'b1; bus.bus_addr = 8'hF3; bus.bus_we = 1'b0; bus.bus_wdata = 8'h00;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk); #1;
            if (mem.mem_req === 1'b1) seen = 1;
        end
        vectors++; if (!seen) begin miscompares++; $display("FAIL rstmid_req: got no mem_req want mem_req"); end
        rst = 1'b1; bus.l2_start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        vectors++; if ({mem.mem_req, bus.l2_done} !== 2'b00) begin miscompares++;
            $display("FAIL rstmid_abort: got req=%b done=%b want 0 0", mem.mem_req, bus.l2_done); end
`ifdef L2_STATS_EN
        vectors++; if ({hit_cnt, miss_cnt} !== 32'h0) begin miscompares++; $display("FAIL rstmid_stats: got %h/%h want 0/0", hit_cnt, miss_cnt); end
`endif
        xact(8'h35, 0, 8'h00, 0);
        vectors++; if ({o_req, o_req_addr, o_rdata} !== {1'b1, 8'h35, mem_arr[8'h35]}) begin miscompares++;
            $display("FAIL rstmid_remiss: got req=%b addr=%h rdata=%h want 1 35 %h", o_req, o_req_addr, o_rdata, mem_arr[8'h35]); end
        model_apply(8'h35, 0, 8'h00);
        finish_xact();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 8'($urandom);
        bus.l2_start = 1'b0; bus.bus_addr = '0; bus.bus_we = 1'b0; bus.bus_wdata = '0;
        mem.mem_ack = 1'b0; mem.mem_rdata = '0;
        rst = 1'b1;
        test_reset();
        test_read_miss_hit();
        test_write();
        test_evict();
        test_hold_and_stray_ack();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
